// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, state encoding and address helpers for the cache controller
package cache_pkg;

    localparam int ADDR_W     = 10;
    localparam int INDEX_W    = 5;
    localparam int OFFSET_W   = 2;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 16;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int ARR_AW     = INDEX_W + OFFSET_W;
    localparam int NUM_BLOCKS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        WR_THRU = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    // Statistics counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_if.sv
// rtl/cache_if.sv - core, data-array and main-memory signals of the cache controller
interface cache_if;
    import cache_pkg::*;

    logic                cpu_rd;
    logic                cpu_wr;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wd;
    logic                stall;
    logic                c_we;
    logic [ARR_AW-1:0]   c_r_addrs;
    logic [ARR_AW-1:0]   c_w_addrs;
    logic [DATA_W-1:0]   c_wd;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wd;
    logic [DATA_W-1:0]   mem_rd;
    logic                mem_ready;
    logic [CNT_W-1:0]    hit_cnt;
    logic [CNT_W-1:0]    miss_cnt;

    modport master (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wd, mem_rd, mem_ready,
        output stall, c_we, c_r_addrs, c_w_addrs, c_wd,
               mem_req, mem_we, mem_addr, mem_wd, hit_cnt, miss_cnt
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wd, mem_rd, mem_ready,
        input  stall, c_we, c_r_addrs, c_w_addrs, c_wd,
               mem_req, mem_we, mem_addr, mem_wd, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/cache_tag_store.sv
// rtl/cache_tag_store.sv - per-block valid bit and tag registers with combinational hit lookup
module cache_tag_store
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    output logic               hit_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q [NUM_BLOCKS];

    // Reset invalidates every block; a write installs the tag and marks the block valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_q[i] <= '0;
            end
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
            tag_q[wr_index_i]   <= wr_tag_i;
        end
    end

    assign hit_o = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through cache sequencer: hit/miss, refill, store-through
module cache_controller
    import cache_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    cache_if.master  bus
);

    state_e               state_q;
    logic [OFFSET_W-1:0]  cnt_q;
    logic [CNT_W-1:0]     hit_cnt_q;
    logic [CNT_W-1:0]     miss_cnt_q;

    logic [TAG_W-1:0]     cpu_tag;
    logic [INDEX_W-1:0]   cpu_index;
    logic                 hit;
    logic                 refill_last;

    assign cpu_tag     = addr_tag(bus.cpu_addr);
    assign cpu_index   = addr_index(bus.cpu_addr);

    // The block becomes valid only when its final word lands, so an aborted refill leaves it invalid
    assign refill_last = (state_q == REFILL) && bus.mem_ready && (cnt_q == {OFFSET_W{1'b1}});

    cache_tag_store u_tags (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (cpu_index),
        .rd_tag_i   (cpu_tag),
        .we_i       (refill_last),
        .wr_index_i (cpu_index),
        .wr_tag_i   (cpu_tag),
        .hit_o      (hit)
    );

    // Sequencer: classifies each access in IDLE, walks the refill words, and retires stores via DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_wr) begin
                        if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
                        else     miss_cnt_q <= sat_inc(miss_cnt_q);
                        state_q <= WR_THRU;
                    end else if (bus.cpu_rd) begin
                        if (hit) begin
                            hit_cnt_q <= sat_inc(hit_cnt_q);
                        end else begin
                            miss_cnt_q <= sat_inc(miss_cnt_q);
                            cnt_q      <= '0;
                            state_q    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (bus.mem_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == {OFFSET_W{1'b1}}) state_q <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (bus.mem_ready) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic                stall_c;
    logic                c_we_c;
    logic [ARR_AW-1:0]   c_w_addrs_c;
    logic [DATA_W-1:0]   c_wd_c;
    logic                mem_req_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;

    // Output decode: IDLE stalls on misses/stores in the same cycle so read hits cost no latency
    always_comb begin
        stall_c     = 1'b0;
        c_we_c      = 1'b0;
        c_w_addrs_c = {cpu_index, cnt_q};
        c_wd_c      = bus.mem_rd;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = bus.cpu_addr;
        case (state_q)
            IDLE: begin
                stall_c = bus.cpu_wr || (bus.cpu_rd && !hit);
            end
            REFILL: begin
                stall_c    = 1'b1;
                mem_req_c  = 1'b1;
                mem_addr_c = {cpu_tag, cpu_index, cnt_q};
                c_we_c     = bus.mem_ready;
            end
            WR_THRU: begin
                stall_c     = 1'b1;
                mem_req_c   = 1'b1;
                mem_we_c    = 1'b1;
                c_w_addrs_c = bus.cpu_addr[ARR_AW-1:0];
                c_wd_c      = bus.cpu_wd;
                // No write allocate: a store miss leaves the data array alone
                c_we_c      = bus.mem_ready && hit;
            end
            default: begin
                stall_c = 1'b0;
            end
        endcase
    end

    assign bus.stall     = stall_c;
    assign bus.c_we      = c_we_c;
    assign bus.c_r_addrs = bus.cpu_addr[ARR_AW-1:0];
    assign bus.c_w_addrs = c_w_addrs_c;
    assign bus.c_wd      = c_wd_c;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wd    = bus.cpu_wd;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;

endmodule
